instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Fetch/execute control stage that feeds the datapath (decoder, registerbank, mux16x1, alu,
//  memorycontrol, addbus_mux, ldr_mux). Replaces the free-running eight_bit_counter as the
//  instruction source. Owns the 8-bit PC and the 32-bit instruction register (IR).
//  Sequences each instruction through FETCH, LOAD_IR, EXEC and the optional MEM and WB states.
//  Drives register write enable, address-bus and LDR mux selects, and taken branches.
// PARAMETERS
//  PC_W      8    PC width; PC wraps modulo 2**PC_W
//  INSTR_W   32   instruction/data word width
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        synchronous, active-high reset
//  enable       in   1        run request; sampled only at instruction boundaries
//  mem_rdata    in   32       RAM read data, valid the cycle after mem_rd=1
//  flag_n/z/c/v in   1 each   ALU flags, sampled in EXEC
//  mem_rd       out  1        instruction fetch read strobe
//  pc_addr      out  32       {24'b0, pc}, feeds addbus_mux PC input
//  ir           out  32       instruction register (replaces 'fetch' bus)
//  reg_we       out  1        one-cycle register write pulse (gates decoder output)
//  seladdbus    out  1        1 = memorycontrol address on bus; 0 = PC
//  selldr       out  1        1 = RAM data to register bank; 0 = ALU result
//  mem_phase    out  1        memorycontrol access enable for LDR/STR
//  halted       out  1        HALT state reached
//  busy         out  1        instruction in flight (state not IDLE/HALT)
// BEHAVIOUR
//  - Opcode ir[27:24]: 0000 NOP; 0001-0111 ALU; 1000 LDR; 1001 STR; 1010 B; 1011 BEQ (z=1);
//    1100 BNE (z=0); 1111 HALT; 1101/1110 treated as NOP. Branch target = ir[7:0].
//  - Reset (sync): state=IDLE, pc=0, ir=0. All strobes/selects (reg_we, mem_rd, mem_phase,
//    seladdbus, selldr) are 0; halted=0, busy=0. Reset overrides every state, including
//    mid-instruction, and never produces a reg_we pulse.
//  - All outputs are registered/Moore, decoded from state and IR.
//  - IDLE: enable=1 -> FETCH, else stay.
//  - FETCH: mem_rd=1, seladdbus=0 -> LOAD_IR.
//  - LOAD_IR: ir<=mem_rdata -> EXEC.
//  - EXEC, by opcode:
//      ALU:    reg_we=1, selldr=0, pc<=pc+1.
//      NOP:    pc<=pc+1.
//      LDR/STR: -> MEM.
//      B/BEQ/BNE: pc<=target if the condition holds, else pc+1.
//      HALT:   -> HALT, pc unchanged.
//  - MEM: mem_phase=1, seladdbus=1.
//      LDR -> WB.
//      STR: pc<=pc+1, then to the boundary.
//  - WB: reg_we=1, selldr=1, seladdbus=1, pc<=pc+1, then to the boundary.
//  - Boundary (end of EXEC/MEM/WB): enable=1 -> FETCH, else -> IDLE.
//    Dropping enable mid-instruction never truncates that instruction.
//  - HALT: halted=1; exits only via reset.
//  - Latency in clocks: ALU/NOP/branch 3, STR 4, LDR 5.
//  - PC arithmetic is PC_W bits: 8'hFF+1 -> 8'h00, with no flag or stall.
//  - A branch to its own address is legal and loops.
// STRUCTURE
//  - Shared package proc_pkg:
//      opcode localparams (OP_NOP, OP_LDR, OP_STR, OP_B, OP_BEQ, OP_BNE, OP_HALT);
//      field slices (OPC 27:24, RD 22:19, RS2 18:15, RS1 14:11, TGT 7:0);
//      state encoding (3-bit: IDLE, FETCH, LOAD_IR, EXEC, MEM, WB, HALT).
//  - Optional sub-module branch_eval: combinational (opcode, flags) -> taken.
//  - Otherwise a single FSM and PC/IR registers.
// TESTING
//  1 Reset: hold reset 2 clks with enable=1.
//    -> pc=0, ir=0, reg_we=0, mem_rd=0, busy=0.
//    Release -> FETCH on next edge; mem_rd=1 with pc_addr=0.
//  2 ALU: RAM[0] = ADD (opc 0001, rd=3).
//    -> reg_we pulses once, 3rd clk after FETCH; pc=1; ir=RAM[0].
//  3 LDR then STR at pc 1,2.
//    -> LDR: mem_phase=1 in clk4, reg_we+selldr=1 in clk5.
//    -> STR: mem_phase=1, no reg_we.
//    -> pc=3 after 9 clks total.
//  4 BEQ tgt=8'h10 with z=1 -> pc=8'h10. Same instruction with z=0 -> pc=old+1.
//    B to self -> pc constant over 3 iterations.
//  5 Wrap: NOP at 8'hFF -> pc=8'h00.
//    Deassert enable during LDR MEM -> WB completes, then IDLE; no further mem_rd.
//  6 HALT: halted=1, busy=0, and pc is frozen for 10 clks.
//    Reset asserted mid-WB -> no reg_we, state IDLE, halted=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the fetch/execute sequencer: opcodes, instruction
// field helpers, FSM state encoding and the registered control word.
package proc_pkg;

    // Opcodes live in ir[27:24]; 0001..0111 are ALU operations and
    // 1101/1110 are reserved and execute as NOP.
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LDR  = 4'b1000;
    localparam logic [3:0] OP_STR  = 4'b1001;
    localparam logic [3:0] OP_B    = 4'b1010;
    localparam logic [3:0] OP_BEQ  = 4'b1011;
    localparam logic [3:0] OP_BNE  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD_IR = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    // Every datapath strobe and select, registered together with the state.
    typedef struct packed {
        logic mem_rd;
        logic reg_we;
        logic seladdbus;
        logic selldr;
        logic mem_phase;
        logic halted;
        logic busy;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Instruction field slices.
    function automatic logic [3:0] field_opc(input logic [31:0] w);
        return w[27:24];
    endfunction

    function automatic logic [3:0] field_rd(input logic [31:0] w);
        return w[22:19];
    endfunction

    function automatic logic [3:0] field_rs2(input logic [31:0] w);
        return w[18:15];
    endfunction

    function automatic logic [3:0] field_rs1(input logic [31:0] w);
        return w[14:11];
    endfunction

    function automatic logic [7:0] field_tgt(input logic [31:0] w);
        return w[7:0];
    endfunction

    // Opcode classes.
    function automatic logic is_alu(input logic [3:0] opc);
        return (opc != OP_NOP) && (opc < OP_LDR);
    endfunction

    function automatic logic is_mem(input logic [3:0] opc);
        return (opc == OP_LDR) || (opc == OP_STR);
    endfunction

    // Moore decode of the control word for the state being entered. The
    // opcode only matters in EXEC, where ALU instructions write the register
    // bank directly from the ALU result.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] opc);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            ST_FETCH: begin
                c.mem_rd = 1'b1;
                c.busy   = 1'b1;
            end
            ST_LOAD_IR: begin
                c.busy = 1'b1;
            end
            ST_EXEC: begin
                c.busy   = 1'b1;
                c.reg_we = is_alu(opc);
            end
            ST_MEM: begin
                c.busy      = 1'b1;
                c.mem_phase = 1'b1;
                c.seladdbus = 1'b1;
            end
            ST_WB: begin
                c.busy      = 1'b1;
                c.reg_we    = 1'b1;
                c.selldr    = 1'b1;
                c.seladdbus = 1'b1;
            end
            ST_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = CTRL_IDLE;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation: decides whether the instruction in EXEC
// redirects the PC to its target field.
module branch_eval
    import proc_pkg::*;
(
    input  logic [3:0] opc,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    output logic       taken
);

    // Only Z participates in the current branch set; N/C/V are carried so
    // signed/carry conditions can be added without touching the top level.
    logic unused_flags;
    assign unused_flags = flag_n ^ flag_c ^ flag_v;

    // Taken decision per branch opcode; non-branch opcodes never redirect.
    always_comb begin
        taken = 1'b0;
        case (opc)
            OP_B:    taken = 1'b1;
            OP_BEQ:  taken = flag_z;
            OP_BNE:  taken = ~flag_z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute control stage. Owns the PC and the instruction register and
// steps each instruction through FETCH, LOAD_IR, EXEC and, for loads and
// stores, MEM and WB. All strobes and selects are registered together with
// the state so they change only on clock edges.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for enable at an instruction boundary
//   FETCH   | mem_rd high, address bus carries the PC
//   LOAD_IR | RAM word for the PC captured into ir
//   EXEC    | ALU write / branch resolve / NOP; LDR,STR go on to MEM
//   MEM     | memorycontrol owns the address bus for the data access
//   WB      | load data written to the register bank
//   HALT    | stopped; only reset leaves this state
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               flag_n,
    input  logic               flag_z,
    input  logic               flag_c,
    input  logic               flag_v,
    output logic               mem_rd,
    output logic [INSTR_W-1:0] pc_addr,
    output logic [INSTR_W-1:0] ir,
    output logic               reg_we,
    output logic               seladdbus,
    output logic               selldr,
    output logic               mem_phase,
    output logic               halted,
    output logic               busy
);

    state_t          state;
    ctrl_t           ctrl;
    logic [PC_W-1:0] pc;
    logic [3:0]      opc;
    logic            taken;
    state_t          boundary_state;

    assign opc = field_opc(ir);

    // Enable is only looked at when an instruction retires, so dropping it
    // mid-instruction lets the current instruction finish.
    assign boundary_state = enable ? ST_FETCH : ST_IDLE;

    branch_eval u_branch_eval (
        .opc    (opc),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .taken  (taken)
    );

    // Sequencer FSM with PC/IR updates and the registered control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
            ctrl  <= CTRL_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_FETCH;
                        ctrl  <= ctrl_for(ST_FETCH, opc);
                    end
                end
                ST_FETCH: begin
                    state <= ST_LOAD_IR;
                    ctrl  <= ctrl_for(ST_LOAD_IR, opc);
                end
                ST_LOAD_IR: begin
                    // The control word for EXEC must come from the word being
                    // loaded, not the stale ir.
                    ir    <= mem_rdata;
                    state <= ST_EXEC;
                    ctrl  <= ctrl_for(ST_EXEC, field_opc(mem_rdata));
                end
                ST_EXEC: begin
                    if (is_mem(opc)) begin
                        state <= ST_MEM;
                        ctrl  <= ctrl_for(ST_MEM, opc);
                    end else if (opc == OP_HALT) begin
                        state <= ST_HALT;
                        ctrl  <= ctrl_for(ST_HALT, opc);
                    end else begin
                        // ALU, NOP, reserved and branch opcodes retire here.
                        pc    <= taken ? field_tgt(ir) : pc + PC_W'(1);
                        state <= boundary_state;
                        ctrl  <= ctrl_for(boundary_state, opc);
                    end
                end
                ST_MEM: begin
                    if (opc == OP_LDR) begin
                        state <= ST_WB;
                        ctrl  <= ctrl_for(ST_WB, opc);
                    end else begin
                        pc    <= pc + PC_W'(1);
                        state <= boundary_state;
                        ctrl  <= ctrl_for(boundary_state, opc);
                    end
                end
                ST_WB: begin
                    pc    <= pc + PC_W'(1);
                    state <= boundary_state;
                    ctrl  <= ctrl_for(boundary_state, opc);
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                    ctrl  <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign pc_addr   = {{(INSTR_W-PC_W){1'b0}}, pc};
    assign mem_rd    = ctrl.mem_rd;
    assign reg_we    = ctrl.reg_we;
    assign seladdbus = ctrl.seladdbus;
    assign selldr    = ctrl.selldr;
    assign mem_phase = ctrl.mem_phase;
    assign halted    = ctrl.halted;
    assign busy      = ctrl.busy;

endmodule
